// File: rtl/seq_stage_controller.sv
// seq_stage_controller: multi-cycle sequencer for the Y86-64 SEQ datapath.
// Owns the architectural PC and processor status, and steps one instruction
// at a time through FETCH, DECODE, EXECUTE, [MEMORY], WRITEBACK and PCUPD.
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   start           begin execution (sampled only in IDLE)
//   icode           instruction code from fetch logic (valid with mem_ready in FETCH)
//   instr_valid     legal-instruction flag, sampled with icode
//   imem_error      fetch address error, sampled with icode
//   mem_ready       completion strobe for the active memory request
//   dmem_error      data address error, sampled with mem_ready in MEMORY
//   new_pc          next PC from PC-update logic, committed in PCUPD
//   pc              architectural PC (fetch address)
//   fetch_req       instruction memory request, high throughout FETCH
//   mem_req         data memory request, high throughout MEMORY
//   dec_en, exe_en, wb_en, pc_en   one-cycle stage enables
//   stat            1=AOK 2=HLT 3=ADR 4=INS
//   busy            high in every state except IDLE and HALT
//   instr_count     retired-instruction counter (wraps)
module seq_stage_controller #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        mem_ready,
  input  logic        dmem_error,
  input  logic [63:0] new_pc,
  output logic [63:0] pc,
  output logic        fetch_req,
  output logic        mem_req,
  output logic        dec_en,
  output logic        exe_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [31:0] instr_count
);

  localparam int unsigned PC_W    = 64;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned STAT_W  = 3;
  localparam int unsigned ICODE_W = 4;

  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  localparam logic [ICODE_W-1:0] I_HALT = 4'h0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [STAT_W-1:0]    r_stat;
  logic [STAT_W-1:0]    w_stat_nxt;
  logic [ICODE_W-1:0]   r_icode_q;
  logic [ICODE_W-1:0]   w_icode_nxt;
  logic [PC_W-1:0]      r_pc;
  logic [CNT_W-1:0]     r_instr_count;
  logic                 r_fetch_req;
  logic                 r_mem_req;
  logic                 r_dec_en;
  logic                 r_exe_en;
  logic                 r_wb_en;
  logic                 r_pc_en;
  logic                 r_busy;
  logic                 w_is_mem_op;

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
  always_comb begin
    w_is_mem_op = 1'b0;
    case (r_icode_q)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: w_is_mem_op = 1'b1;
      default:                            w_is_mem_op = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic, plus the status/icode values captured on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_stat_nxt  = r_stat;
    w_icode_nxt = r_icode_q;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        // Fault priority: address error, then illegal instruction, then halt.
        if (mem_ready) begin
          if (imem_error) begin
            w_state_nxt = S_HALT;
            w_stat_nxt  = STAT_ADR;
          end else if (!instr_valid) begin
            w_state_nxt = S_HALT;
            w_stat_nxt  = STAT_INS;
          end else if (icode == I_HALT) begin
            w_state_nxt = S_HALT;
            w_stat_nxt  = STAT_HLT;
          end else begin
            w_state_nxt = S_DECODE;
            w_icode_nxt = icode;
          end
        end
      end
      S_DECODE: begin
        w_state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_state_nxt = w_is_mem_op ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (dmem_error) begin
            w_state_nxt = S_HALT;
            w_stat_nxt  = STAT_ADR;
          end else begin
            w_state_nxt = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        w_state_nxt = S_PCUPD;
      end
      S_PCUPD: begin
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Architectural state: PC and retire count only move on a PCUPD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instr_count <= '0;
      r_stat        <= STAT_AOK;
      r_icode_q     <= '0;
    end else begin
      r_stat    <= w_stat_nxt;
      r_icode_q <= w_icode_nxt;
      if (r_state == S_PCUPD) begin
        r_pc          <= new_pc;
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  // Moore outputs registered from the next state so each one is high exactly
  // while the state register holds the matching state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_req <= 1'b0;
      r_dec_en    <= 1'b0;
      r_exe_en    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_wb_en     <= 1'b0;
      r_pc_en     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_fetch_req <= (w_state_nxt == S_FETCH);
      r_dec_en    <= (w_state_nxt == S_DECODE);
      r_exe_en    <= (w_state_nxt == S_EXECUTE);
      r_mem_req   <= (w_state_nxt == S_MEMORY);
      r_wb_en     <= (w_state_nxt == S_WRITEBACK);
      r_pc_en     <= (w_state_nxt == S_PCUPD);
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALT);
    end
  end

  assign pc          = r_pc;
  assign instr_count = r_instr_count;
  assign stat        = r_stat;
  assign fetch_req   = r_fetch_req;
  assign dec_en      = r_dec_en;
  assign exe_en      = r_exe_en;
  assign mem_req     = r_mem_req;
  assign wb_en       = r_wb_en;
  assign pc_en       = r_pc_en;
  assign busy        = r_busy;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Self-checking bench for seq_stage_controller. A small model expands each
// instruction into per-cycle stimulus plus the outputs expected after the
// following clock edge; those expectations go through a scoreboard queue and
// are compared one cycle later.
module tb_seq_stage_controller;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic        mem_ready;
  logic        dmem_error;
  logic [63:0] new_pc;
  logic [63:0] pc;
  logic        fetch_req, mem_req, dec_en, exe_en, wb_en, pc_en, busy;
  logic [2:0]  stat;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  seq_stage_controller #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .mem_ready(mem_ready),
    .dmem_error(dmem_error), .new_pc(new_pc), .pc(pc), .fetch_req(fetch_req),
    .mem_req(mem_req), .dec_en(dec_en), .exe_en(exe_en), .wb_en(wb_en),
    .pc_en(pc_en), .stat(stat), .busy(busy), .instr_count(instr_count)
  );

  typedef enum int {E_IDLE, E_FETCH, E_DECODE, E_EXECUTE, E_MEMORY, E_WB, E_PCUPD, E_HALT} est_t;

  typedef struct {
    logic        st;
    logic        rdy;
    logic [3:0]  ic;
    logic        iv;
    logic        ie;
    logic        de;
    logic [63:0] npc;
    logic [6:0]  ctl;
    logic [63:0] pc;
    logic [31:0] cnt;
    logic [2:0]  stat;
  } step_t;

  step_t       plan[$];
  step_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  logic [2:0]  m_stat;

  // {fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy}
  function automatic logic [6:0] ctl_of(input est_t s);
    case (s)
      E_FETCH:   return 7'b1000001;
      E_DECODE:  return 7'b0100001;
      E_EXECUTE: return 7'b0010001;
      E_MEMORY:  return 7'b0001001;
      E_WB:      return 7'b0000101;
      E_PCUPD:   return 7'b0000011;
      default:   return 7'b0000000;
    endcase
  endfunction

  task automatic add_step(input logic st, input logic rdy, input logic [3:0] ic,
                          input logic iv, input logic ie, input logic de,
                          input logic [63:0] npc, input est_t s);
    step_t x;
    x.st = st; x.rdy = rdy; x.ic = ic; x.iv = iv; x.ie = ie; x.de = de; x.npc = npc;
    x.ctl = ctl_of(s); x.pc = m_pc; x.cnt = m_cnt; x.stat = m_stat;
    plan.push_back(x);
  endtask

  // Model of one instruction; leaves the DUT in FETCH unless it halts/aborts.
  task automatic plan_instr(input logic from_idle, input logic [3:0] ic, input int fwait,
                            input int mwait, input logic ie, input logic iv, input logic de,
                            input logic [63:0] npc, input logic abort_mem);
    logic is_mem;
    if (from_idle) add_step(1'b1, 1'b1, ic, 1'b1, 1'b0, 1'b0, npc, E_FETCH);
    repeat (fwait) add_step(1'b0, 1'b0, ic, 1'b1, 1'b0, 1'b0, npc, E_FETCH);
    if (ie) begin
      m_stat = 3'd3; add_step(1'b0, 1'b1, ic, iv, 1'b1, 1'b0, npc, E_HALT); return;
    end
    if (!iv) begin
      m_stat = 3'd4; add_step(1'b0, 1'b1, ic, 1'b0, 1'b0, 1'b0, npc, E_HALT); return;
    end
    if (ic == 4'h0) begin
      m_stat = 3'd2; add_step(1'b0, 1'b1, ic, 1'b1, 1'b0, 1'b0, npc, E_HALT); return;
    end
    add_step(1'b0, 1'b1, ic, 1'b1, 1'b0, 1'b0, npc, E_DECODE);
    add_step(1'b0, 1'b1, ic, 1'b1, 1'b0, 1'b0, npc, E_EXECUTE);
    is_mem = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
             (ic == 4'hA) || (ic == 4'hB);
    add_step(1'b0, 1'b1, ic, 1'b1, 1'b0, 1'b0, npc, is_mem ? E_MEMORY : E_WB);
    if (is_mem) begin
      repeat (mwait) add_step(1'b0, 1'b0, ic, 1'b1, 1'b0, 1'b0, npc, E_MEMORY);
      if (abort_mem) return;
      if (de) begin
        m_stat = 3'd3; add_step(1'b0, 1'b1, ic, 1'b1, 1'b0, 1'b1, npc, E_HALT); return;
      end
      add_step(1'b0, 1'b1, ic, 1'b1, 1'b0, 1'b0, npc, E_WB);
    end
    add_step(1'b0, 1'b1, ic, 1'b1, 1'b0, 1'b0, npc, E_PCUPD);
    m_pc = npc;
    m_cnt = m_cnt + 32'd1;
    add_step(1'b0, 1'b1, ic, 1'b1, 1'b0, 1'b0, npc, E_FETCH);
  endtask

  // Drive one planned cycle and hand its expectation to the scoreboard.
  task automatic drive_step(input step_t s);
    start = s.st; mem_ready = s.rdy; icode = s.ic; instr_valid = s.iv;
    imem_error = s.ie; dmem_error = s.de; new_pc = s.npc;
    sb.push_back(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; mem_ready = 1'b0; icode = 4'h0; instr_valid = 1'b1;
    imem_error = 1'b0; dmem_error = 1'b0; new_pc = 64'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = RST_PC; m_cnt = 32'd0; m_stat = 3'd1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
    checks++; if (stat !== 3'd1) begin errors++; $display("FAIL reset_stat: got %0d expected 1", stat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    checks++;
    if ({fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en} !== 6'b0) begin
      errors++; $display("FAIL reset_enables: got %b expected 000000",
                         {fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en});
    end
    rst_n = 1'b1;
    m_pc = RST_PC; m_cnt = 32'd0; m_stat = 3'd1;
  endtask

  // irmovq then mrmovq with three data wait cycles, run back to back.
  task automatic test_irmovq_mrmovq();
    step_t s, e;
    int cyc = 0;
    int memc = 0;
    plan_instr(1'b1, 4'h3, 0, 0, 1'b0, 1'b1, 1'b0, 64'h10A, 1'b0);
    plan_instr(1'b0, 4'h5, 0, 3, 1'b0, 1'b1, 1'b0, 64'h2F0, 1'b0);
    while (plan.size() != 0) begin
      s = plan.pop_front();
      drive_step(s);
      @(negedge clk);
      e = sb.pop_front();
      cyc++;
      if (mem_req === 1'b1) memc++;
      checks++;
      if ({fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy} !== e.ctl) begin
        errors++; $display("FAIL seq_ctl cycle %0d: got %b expected %b", cyc,
                           {fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy}, e.ctl);
      end
      checks++;
      if (pc !== e.pc || instr_count !== e.cnt || stat !== e.stat) begin
        errors++; $display("FAIL seq_arch cycle %0d: got pc=%h cnt=%0d stat=%0d expected pc=%h cnt=%0d stat=%0d",
                           cyc, pc, instr_count, stat, e.pc, e.cnt, e.stat);
      end
    end
    checks++; if (memc !== 4) begin errors++; $display("FAIL mrmovq_mem_req_cycles: got %0d expected 4", memc); end
  endtask

  // Two nops then halt; a later start must be ignored.
  task automatic test_halt();
    step_t s, e;
    int cyc = 0;
    do_reset();
    plan_instr(1'b1, 4'h1, 0, 0, 1'b0, 1'b1, 1'b0, RST_PC + 64'd1, 1'b0);
    plan_instr(1'b0, 4'h1, 1, 0, 1'b0, 1'b1, 1'b0, RST_PC + 64'd2, 1'b0);
    plan_instr(1'b0, 4'h0, 0, 0, 1'b0, 1'b1, 1'b0, 64'hDEAD, 1'b0);
    add_step(1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 64'hBEEF, E_HALT);
    add_step(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 64'hBEEF, E_HALT);
    while (plan.size() != 0) begin
      s = plan.pop_front();
      drive_step(s);
      @(negedge clk);
      e = sb.pop_front();
      cyc++;
      checks++;
      if ({fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy} !== e.ctl) begin
        errors++; $display("FAIL halt_ctl cycle %0d: got %b expected %b", cyc,
                           {fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy}, e.ctl);
      end
      checks++;
      if (pc !== e.pc || instr_count !== e.cnt || stat !== e.stat) begin
        errors++; $display("FAIL halt_arch cycle %0d: got pc=%h cnt=%0d stat=%0d expected pc=%h cnt=%0d stat=%0d",
                           cyc, pc, instr_count, stat, e.pc, e.cnt, e.stat);
      end
    end
    checks++;
    if (pc !== RST_PC + 64'd2 || stat !== 3'd2 || instr_count !== 32'd2) begin
      errors++; $display("FAIL halt_final: got pc=%h stat=%0d cnt=%0d expected pc=%h stat=2 cnt=2",
                         pc, stat, instr_count, RST_PC + 64'd2);
    end
  endtask

  // 0: imem_error, 1: illegal instruction, 2: nop then pushq with dmem_error.
  task automatic test_faults();
    step_t s, e;
    int cyc;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      cyc = 0;
      case (k)
        0: plan_instr(1'b1, 4'h2, 2, 0, 1'b1, 1'b1, 1'b0, 64'h500, 1'b0);
        1: plan_instr(1'b1, 4'hC, 0, 0, 1'b0, 1'b0, 1'b0, 64'h500, 1'b0);
        default: begin
          plan_instr(1'b1, 4'h1, 0, 0, 1'b0, 1'b1, 1'b0, 64'h180, 1'b0);
          plan_instr(1'b0, 4'hA, 0, 2, 1'b0, 1'b1, 1'b1, 64'h18A, 1'b0);
        end
      endcase
      add_step(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 64'h0, E_HALT);
      while (plan.size() != 0) begin
        s = plan.pop_front();
        drive_step(s);
        @(negedge clk);
        e = sb.pop_front();
        cyc++;
        checks++;
        if ({fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy} !== e.ctl) begin
          errors++; $display("FAIL fault%0d_ctl cycle %0d: got %b expected %b", k, cyc,
                             {fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy}, e.ctl);
        end
        checks++;
        if (pc !== e.pc || instr_count !== e.cnt || stat !== e.stat) begin
          errors++; $display("FAIL fault%0d_arch cycle %0d: got pc=%h cnt=%0d stat=%0d expected pc=%h cnt=%0d stat=%0d",
                             k, cyc, pc, instr_count, stat, e.pc, e.cnt, e.stat);
        end
      end
    end
  endtask

  // Async reset while MEMORY is waiting, then a fresh start from RESET_PC.
  task automatic test_reset_mid_memory();
    step_t s, e;
    int cyc = 0;
    do_reset();
    plan_instr(1'b1, 4'h1, 0, 0, 1'b0, 1'b1, 1'b0, 64'h140, 1'b0);
    plan_instr(1'b0, 4'h5, 0, 2, 1'b0, 1'b1, 1'b0, 64'h14A, 1'b1);
    while (plan.size() != 0) begin
      s = plan.pop_front();
      drive_step(s);
      @(negedge clk);
      e = sb.pop_front();
      cyc++;
      checks++;
      if ({fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy} !== e.ctl) begin
        errors++; $display("FAIL abort_ctl cycle %0d: got %b expected %b", cyc,
                           {fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy}, e.ctl);
      end
      checks++;
      if (pc !== e.pc || instr_count !== e.cnt || stat !== e.stat) begin
        errors++; $display("FAIL abort_arch cycle %0d: got pc=%h cnt=%0d stat=%0d expected pc=%h cnt=%0d stat=%0d",
                           cyc, pc, instr_count, stat, e.pc, e.cnt, e.stat);
      end
    end
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || pc !== RST_PC || instr_count !== 32'd0 || stat !== 3'd1) begin
      errors++; $display("FAIL abort_async: got mem_req=%b busy=%b pc=%h cnt=%0d stat=%0d expected 0 0 %h 0 1",
                         mem_req, busy, pc, instr_count, stat, RST_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RST_PC; m_cnt = 32'd0; m_stat = 3'd1;
    cyc = 0;
    plan_instr(1'b1, 4'h6, 0, 0, 1'b0, 1'b1, 1'b0, 64'h10C, 1'b0);
    while (plan.size() != 0) begin
      s = plan.pop_front();
      drive_step(s);
      @(negedge clk);
      e = sb.pop_front();
      cyc++;
      checks++;
      if ({fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy} !== e.ctl) begin
        errors++; $display("FAIL restart_ctl cycle %0d: got %b expected %b", cyc,
                           {fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en, busy}, e.ctl);
      end
      checks++;
      if (pc !== e.pc || instr_count !== e.cnt || stat !== e.stat) begin
        errors++; $display("FAIL restart_arch cycle %0d: got pc=%h cnt=%0d stat=%0d expected pc=%h cnt=%0d stat=%0d",
                           cyc, pc, instr_count, stat, e.pc, e.cnt, e.stat);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; mem_ready = 1'b0; icode = 4'h0; instr_valid = 1'b1;
    imem_error = 1'b0; dmem_error = 1'b0; new_pc = 64'h0;
    m_pc = RST_PC; m_cnt = 32'd0; m_stat = 3'd1;
    test_reset();
    test_irmovq_mrmovq();
    test_halt();
    test_faults();
    test_reset_mid_memory();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
